// File: rtl/spi_bus_arbiter_if.sv
// Signal bundle between the Wishbone byte requesters, the SPI bus arbiter and the SPI master.
// The master modport is the arbiter's view; the slave modport is the view of the surrounding logic.
interface spi_bus_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8
);
   logic [NUM_REQ-1:0]        req_stb_i, req_we_i, req_lock_i;
   logic [NUM_REQ*ADDR_W-1:0] req_adr_i;
   logic [NUM_REQ*DATA_W-1:0] req_dat_i;
   logic [NUM_REQ-1:0]        req_ack_o, req_err_o, req_rty_o;
   logic [DATA_W-1:0]         req_dat_o;
   logic [NUM_REQ-1:0]        grant_o;
   logic                      STB_O, WE_O;
   logic [ADDR_W-1:0]         ADR_O;
   logic [DATA_W-1:0]         DAT_O;
   logic                      ACK_I, RTY_I;
   logic [DATA_W-1:0]         DAT_I;

   modport master (
      input  req_stb_i, req_we_i, req_lock_i, req_adr_i, req_dat_i, ACK_I, RTY_I, DAT_I,
      output req_ack_o, req_err_o, req_rty_o, req_dat_o, grant_o, STB_O, WE_O, ADR_O, DAT_O
   );
   modport slave (
      output req_stb_i, req_we_i, req_lock_i, req_adr_i, req_dat_i, ACK_I, RTY_I, DAT_I,
      input  req_ack_o, req_err_o, req_rty_o, req_dat_o, grant_o, STB_O, WE_O, ADR_O, DAT_O
   );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ byte requesters,
// with bus locking for bursts and a watchdog on the master's acknowledge.
module spi_bus_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic CLK_I,
   input  logic RST_I,
   spi_bus_arbiter_if.master bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, ACKD, HOLD} state_t;

   state_t              state, stateNxt;
   logic [IDX_W-1:0]    ptr, ptrNxt, owner, ownerNxt, hitIdx, cand, selIdx;
   logic [WD_W-1:0]     wdog, wdogNxt;
   logic [NUM_REQ-1:0]  grantNxt, ackNxt, errNxt;
   logic                hit, rls, stbNxt, weNxt, weSel;
   logic [ADDR_W-1:0]   adrNxt, adrSel;
   logic [DATA_W-1:0]   datNxt, datSel, rdNxt;
   logic [ADDR_W-1:0]   adrArr [NUM_REQ];
   logic [DATA_W-1:0]   datArr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign adrArr[i] = bus.req_adr_i[i*ADDR_W +: ADDR_W];
      assign datArr[i] = bus.req_dat_i[i*DATA_W +: DATA_W];
   end

   assign bus.req_rty_o = bus.req_stb_i & ~bus.grant_o;

   // Walk from the farthest candidate back to the pointer so the nearest hit wins.
   always_comb begin
      hit    = 1'b0;
      hitIdx = '0;
      cand   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
         if (bus.req_stb_i[cand]) begin
            hit    = 1'b1;
            hitIdx = cand;
         end
      end
   end

   assign selIdx = (state == IDLE) ? hitIdx : owner;
   assign weSel  = bus.req_we_i[selIdx];
   assign adrSel = adrArr[selIdx];
   assign datSel = datArr[selIdx];

   always_comb begin
      stateNxt = state;
      ptrNxt   = ptr;
      ownerNxt = owner;
      wdogNxt  = wdog;
      grantNxt = bus.grant_o;
      stbNxt   = bus.STB_O;
      weNxt    = bus.WE_O;
      adrNxt   = bus.ADR_O;
      datNxt   = bus.DAT_O;
      rdNxt    = bus.req_dat_o;
      ackNxt   = '0;
      errNxt   = '0;
      rls      = 1'b0;
      case (state)
         IDLE: if (hit) begin
            ownerNxt = hitIdx;
            grantNxt = NUM_REQ'(1) << hitIdx;
            weNxt    = weSel;
            adrNxt   = adrSel;
            datNxt   = datSel;
            stbNxt   = 1'b1;
            stateNxt = ISSUE;
         end
         ISSUE: begin
            if (!bus.req_stb_i[owner]) begin
               stbNxt = 1'b0;
               rls    = 1'b1;
            end else if (!bus.RTY_I) begin
               stbNxt   = 1'b0;
               wdogNxt  = '0;
               stateNxt = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            wdogNxt = wdog + 1'b1;
            if (bus.ACK_I) begin
               rdNxt         = bus.DAT_I;
               ackNxt[owner] = 1'b1;
               stateNxt      = ACKD;
            end else if (wdog == WD_W'(TIMEOUT_CYC - 1)) begin
               errNxt[owner] = 1'b1;
               rls           = 1'b1;
            end
         end
         ACKD: begin
            if (bus.req_lock_i[owner]) stateNxt = HOLD;
            else                       rls      = 1'b1;
         end
         HOLD: begin
            if (bus.req_stb_i[owner]) begin
               weNxt    = weSel;
               adrNxt   = adrSel;
               datNxt   = datSel;
               stbNxt   = 1'b1;
               stateNxt = ISSUE;
            end else if (!bus.req_lock_i[owner]) begin
               rls = 1'b1;
            end
         end
         default: stateNxt = IDLE;
      endcase
      if (rls) begin
         grantNxt = '0;
         stateNxt = IDLE;
         ptrNxt   = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
      end
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state         <= IDLE;
         ptr           <= '0;
         owner         <= '0;
         wdog          <= '0;
         bus.grant_o   <= '0;
         bus.STB_O     <= 1'b0;
         bus.WE_O      <= 1'b0;
         bus.ADR_O     <= '0;
         bus.DAT_O     <= '0;
         bus.req_dat_o <= '0;
         bus.req_ack_o <= '0;
         bus.req_err_o <= '0;
      end else begin
         state         <= stateNxt;
         ptr           <= ptrNxt;
         owner         <= ownerNxt;
         wdog          <= wdogNxt;
         bus.grant_o   <= grantNxt;
         bus.STB_O     <= stbNxt;
         bus.WE_O      <= weNxt;
         bus.ADR_O     <= adrNxt;
         bus.DAT_O     <= datNxt;
         bus.req_dat_o <= rdNxt;
         bus.req_ack_o <= ackNxt;
         bus.req_err_o <= errNxt;
      end
   end
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter: requester and SPI master models, with a
// monitor comparing every accepted bus byte and every ack/err pulse against queued expectations.
`timescale 1ns/1ps
module tb_spi_bus_arbiter;
   localparam int NR = 2, AW = 8, DW = 8, TO = 16;

   logic CLK_I = 1'b0;
   logic RST_I = 1'b0;
   always #5 CLK_I = ~CLK_I;

   spi_bus_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();
   spi_bus_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
      .CLK_I(CLK_I), .RST_I(RST_I), .bus(bus)
   );

   typedef struct { logic [AW-1:0] adr; logic [DW-1:0] dat; logic we; logic lock; } reqItem_t;
   typedef struct { logic [NR-1:0] grant; logic [AW-1:0] adr; logic [DW-1:0] dat; logic we; } busExp_t;
   typedef struct { logic err; int who; logic [DW-1:0] dat; } rspExp_t;
   typedef struct { logic ack; logic [DW-1:0] dat; } rdItem_t;

   reqItem_t reqQ [NR][$];
   busExp_t  busQ [$];
   rspExp_t  rspQ [$];
   rdItem_t  rdQ  [$];
   int checks = 0, failures = 0;
   int ackDelay = 3;
   bit busy [NR];
   bit done [NR];
   int waitCnt [NR];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic pushReq(input int i, input logic [7:0] adr, dat, input logic we, lock);
      reqItem_t it;
      it.adr = adr; it.dat = dat; it.we = we; it.lock = lock;
      reqQ[i].push_back(it);
   endtask
   task automatic expBus(input logic [NR-1:0] g, input logic [7:0] adr, dat, input logic we);
      busExp_t b;
      b.grant = g; b.adr = adr; b.dat = dat; b.we = we;
      busQ.push_back(b);
   endtask
   task automatic expRsp(input logic err, input int who, input logic [7:0] dat);
      rspExp_t r;
      r.err = err; r.who = who; r.dat = dat;
      rspQ.push_back(r);
   endtask
   task automatic pushRd(input logic ack, input logic [7:0] dat);
      rdItem_t r;
      r.ack = ack; r.dat = dat;
      rdQ.push_back(r);
   endtask

   // Requester model: holds stb/we/adr/dat/lock until its ack or err, then loads the next item.
   initial begin
      reqItem_t it;
      bus.req_stb_i = '0; bus.req_we_i = '0; bus.req_lock_i = '0;
      bus.req_adr_i = '0; bus.req_dat_i = '0;
      for (int i = 0; i < NR; i++) begin busy[i] = 0; done[i] = 0; waitCnt[i] = 0; end
      forever begin
         @(negedge CLK_I);
         for (int i = 0; i < NR; i++)
            if (busy[i] && (bus.req_ack_o[i] || bus.req_err_o[i])) done[i] = 1;
         @(posedge CLK_I); #1;
         for (int i = 0; i < NR; i++) begin
            if (RST_I) begin
               busy[i] = 0; done[i] = 0;
            end else if (busy[i] && !done[i]) begin
               waitCnt[i]++;
               if (waitCnt[i] > 500) begin
                  checks++; failures++;
                  $display("FAIL req_wait requester=%0d actual=no_response required=ack_or_err", i);
                  busy[i] = 0;
               end
            end
            if (!busy[i] || done[i]) begin
               if (!RST_I && reqQ[i].size() != 0) begin
                  it = reqQ[i].pop_front();
                  bus.req_stb_i[i]          = 1'b1;
                  bus.req_we_i[i]           = it.we;
                  bus.req_lock_i[i]         = it.lock;
                  bus.req_adr_i[i*AW +: AW] = it.adr;
                  bus.req_dat_i[i*DW +: DW] = it.dat;
                  busy[i] = 1; done[i] = 0; waitCnt[i] = 0;
               end else begin
                  bus.req_stb_i[i] = 1'b0; bus.req_lock_i[i] = 1'b0;
                  busy[i] = 0; done[i] = 0;
               end
            end
         end
      end
   end

   // SPI master model: acknowledges an accepted byte ackDelay cycles later unless told not to.
   initial begin
      rdItem_t r;
      bus.ACK_I = 1'b0; bus.DAT_I = '0;
      forever begin
         @(negedge CLK_I);
         if (!RST_I && bus.STB_O && !bus.RTY_I && rdQ.size() != 0) begin
            r = rdQ.pop_front();
            if (r.ack) begin
               repeat (ackDelay) @(posedge CLK_I);
               #1 bus.ACK_I = 1'b1; bus.DAT_I = r.dat;
               @(posedge CLK_I);
               #1 bus.ACK_I = 1'b0;
            end
         end
      end
   end

   // Monitor: every accepted byte and every ack/err pulse is matched against the scoreboard.
   initial begin
      busExp_t b;
      rspExp_t r;
      logic [NR-1:0] oh;
      forever begin
         @(negedge CLK_I);
         if (!RST_I && bus.STB_O && !bus.RTY_I) begin
            if (busQ.size() == 0) begin
               checks++; failures++;
               $display("FAIL bus_unexpected actual=grant %0b dat %0h required=no_byte", bus.grant_o, bus.DAT_O);
            end else begin
               b = busQ.pop_front();
               chk("bus_byte", {bus.grant_o, bus.ADR_O, bus.DAT_O, 7'd0, bus.WE_O},
                               {b.grant, b.adr, b.dat, 7'd0, b.we});
            end
         end
         if ((|bus.req_ack_o) || (|bus.req_err_o)) begin
            if (rspQ.size() == 0) begin
               checks++; failures++;
               $display("FAIL rsp_unexpected actual=ack %0b err %0b required=none", bus.req_ack_o, bus.req_err_o);
            end else begin
               r = rspQ.pop_front();
               oh = '0; oh[r.who] = 1'b1;
               chk("rsp_ack_err", {bus.req_ack_o, bus.req_err_o},
                   r.err ? {{NR{1'b0}}, oh} : {oh, {NR{1'b0}}});
               if (!r.err) chk("rsp_dat", bus.req_dat_o, r.dat);
            end
         end
      end
   end

   task automatic waitStb(input logic lvl, input string nm);
      int n;
      @(negedge CLK_I);
      n = 0;
      while (bus.STB_O !== lvl && n < 100) begin @(negedge CLK_I); n++; end
      if (n >= 100) begin
         checks++; failures++;
         $display("FAIL %s actual=STB_O %0b required=%0b", nm, bus.STB_O, lvl);
      end
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      @(negedge CLK_I);
      while (!(reqQ[0].size() == 0 && reqQ[1].size() == 0 && !busy[0] && !busy[1] &&
               busQ.size() == 0 && rspQ.size() == 0 && bus.grant_o == '0) && n < 3000) begin
         @(negedge CLK_I); n++;
      end
      chk(nm, {31'd0, n < 3000}, 32'd1);
   endtask

   task automatic doReset();
      @(posedge CLK_I); #2 RST_I = 1'b1;
      repeat (2) @(posedge CLK_I);
      #2 RST_I = 1'b0;
   endtask

   initial begin
      int cnt;
      bus.RTY_I = 1'b0;
      #2 RST_I = 1'b1;
      @(negedge CLK_I);
      chk("rst_grant", bus.grant_o, 0);
      chk("rst_stb_we", {bus.STB_O, bus.WE_O}, 0);
      chk("rst_adr_dat", {bus.ADR_O, bus.DAT_O}, 0);
      chk("rst_ack_err", {bus.req_ack_o, bus.req_err_o}, 0);
      chk("rst_rdat", bus.req_dat_o, 0);
      @(posedge CLK_I); #2 RST_I = 1'b0;

      // single byte from requester 0, ack 10 cycles after acceptance
      ackDelay = 10;
      pushRd(1, 8'h5C); expBus(2'b01, 8'h00, 8'h2A, 1); expRsp(0, 0, 8'h5C);
      pushReq(0, 8'h00, 8'h2A, 1, 0);
      waitStb(1, "t1_stb_rise");
      cnt = 0;
      while (bus.STB_O && cnt < 50) begin cnt++; @(negedge CLK_I); end
      chk("t1_stb_len", cnt, 1);
      drain("t1_drain");
      chk("t1_grant_idle", bus.grant_o, 0);

      // both requesters continuously, unlocked: grants alternate 0,1,0,1
      doReset();
      ackDelay = 3;
      pushRd(1, 8'hA1); pushRd(1, 8'hB1); pushRd(1, 8'hA2); pushRd(1, 8'hB2);
      expBus(2'b01, 8'h10, 8'h11, 1); expBus(2'b10, 8'h20, 8'h21, 0);
      expBus(2'b01, 8'h12, 8'h13, 1); expBus(2'b10, 8'h22, 8'h23, 0);
      expRsp(0, 0, 8'hA1); expRsp(0, 1, 8'hB1); expRsp(0, 0, 8'hA2); expRsp(0, 1, 8'hB2);
      pushReq(0, 8'h10, 8'h11, 1, 0); pushReq(0, 8'h12, 8'h13, 1, 0);
      pushReq(1, 8'h20, 8'h21, 0, 0); pushReq(1, 8'h22, 8'h23, 0, 0);
      waitStb(1, "t2_stb_rise");
      chk("t2_grant_first", bus.grant_o, 2'b01);
      chk("t2_rty_waiting", bus.req_rty_o, 2'b10);
      drain("t2_drain");

      // locked 3-byte burst from requester 0 while requester 1 waits
      pushRd(1, 8'h61); pushRd(1, 8'h62); pushRd(1, 8'h63); pushRd(1, 8'h64);
      expBus(2'b01, 8'h00, 8'h2C, 1); expBus(2'b01, 8'h00, 8'h12, 1);
      expBus(2'b01, 8'h00, 8'h34, 1); expBus(2'b10, 8'h01, 8'h55, 1);
      expRsp(0, 0, 8'h61); expRsp(0, 0, 8'h62); expRsp(0, 0, 8'h63); expRsp(0, 1, 8'h64);
      pushReq(0, 8'h00, 8'h2C, 1, 1); pushReq(0, 8'h00, 8'h12, 1, 1); pushReq(0, 8'h00, 8'h34, 1, 0);
      pushReq(1, 8'h01, 8'h55, 1, 0);
      waitStb(1, "t3_stb_rise");
      chk("t3_rty_waiting", bus.req_rty_o, 2'b10);
      drain("t3_drain");

      // master busy for 20 cycles after grant
      bus.RTY_I = 1'b1;
      pushRd(1, 8'h77); expBus(2'b01, 8'h05, 8'h9A, 0); expRsp(0, 0, 8'h77);
      pushReq(0, 8'h05, 8'h9A, 0, 0);
      waitStb(1, "t4_stb_rise");
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (bus.STB_O && bus.DAT_O == 8'h9A) cnt++;
         if (k < 19) @(negedge CLK_I);
      end
      chk("t4_rty_hold", cnt, 20);
      @(posedge CLK_I); #1 bus.RTY_I = 1'b0;
      @(negedge CLK_I);
      @(negedge CLK_I);
      chk("t4_stb_drop", bus.STB_O, 0);
      drain("t4_drain");

      // watchdog: requester 1 never acked, then requester 0 serviced
      pushRd(0, 8'h00); pushRd(1, 8'h88);
      expBus(2'b10, 8'h03, 8'hE1, 1); expBus(2'b01, 8'h04, 8'hE2, 1);
      expRsp(1, 1, 8'h00); expRsp(0, 0, 8'h88);
      pushReq(1, 8'h03, 8'hE1, 1, 0); pushReq(0, 8'h04, 8'hE2, 1, 0);
      waitStb(1, "t5_stb_rise");
      waitStb(0, "t5_stb_fall");
      cnt = 0;
      while (!(|bus.req_err_o) && cnt < 40) begin @(negedge CLK_I); cnt++; end
      chk("t5_err_latency", cnt, TO);
      chk("t5_grant_at_err", bus.grant_o, 0);
      drain("t5_drain");

      // async reset while waiting for ack
      pushRd(0, 8'h00); expBus(2'b10, 8'h07, 8'hF0, 1);
      pushReq(1, 8'h07, 8'hF0, 1, 0);
      waitStb(1, "t6_stb_rise");
      waitStb(0, "t6_stb_fall");
      repeat (3) @(posedge CLK_I);
      #2 RST_I = 1'b1;
      #1;
      chk("t6_rst_grant", bus.grant_o, 0);
      chk("t6_rst_stb", bus.STB_O, 0);
      chk("t6_rst_dat", {bus.DAT_O, bus.ADR_O, bus.req_dat_o}, 0);
      chk("t6_rst_ack_err", {bus.req_ack_o, bus.req_err_o}, 0);
      repeat (3) @(posedge CLK_I);
      #1 RST_I = 1'b0;
      @(posedge CLK_I); #2;
      pushRd(1, 8'hA5); pushRd(1, 8'h5A);
      expBus(2'b01, 8'h08, 8'hC1, 1); expBus(2'b10, 8'h09, 8'hC2, 1);
      expRsp(0, 0, 8'hA5); expRsp(0, 1, 8'h5A);
      pushReq(0, 8'h08, 8'hC1, 1, 0); pushReq(1, 8'h09, 8'hC2, 1, 0);
      drain("t6_drain");
      chk("t6_rdq_empty", rdQ.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end
endmodule
